apb_master_mc: RTL and testbench

- Parametrised APB master bridge, next generation of the single-select APB master interface.
- Accepts one request at a time from an internal requester over a valid/ready channel and decodes the address to one of SLAVE_DEVICES one-hot psel lines.
- Runs the APB SETUP/ACCESS protocol with wait-state timeout and returns a response over a valid/ready channel with a 2-bit error code.
- Sits between a bus fabric or CPU-side port and up to SLAVE_DEVICES APB peripherals; per-slave prdata/pready/pslverr are muxed internally.

---
 rtl/apb_master_mc_if.sv | 45 ++++
 rtl/apb_master_mc.sv | 148 ++++++++++++++
 tb/tb_apb_master_mc.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_mc_if.sv
// apb_master_mc_if: request/response channels and APB bus of the multi-select APB master
interface apb_master_mc_if #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int SLAVE_DEVICES  = 4
);
    localparam int SW = APB_DATA_WIDTH / 8;
    logic                                    req_valid_in;
    logic                                    req_ready_out;
    logic [APB_ADDR_WIDTH-1:0]               req_addr_in;
    logic                                    req_write_in;
    logic [APB_DATA_WIDTH-1:0]               req_wdata_in;
    logic [SW-1:0]                           req_strb_in;
    logic [2:0]                              req_prot_in;
    logic                                    rsp_valid_out;
    logic                                    rsp_ready_in;
    logic [APB_DATA_WIDTH-1:0]               rsp_rdata_out;
    logic [1:0]                              rsp_err_out;
    logic [APB_ADDR_WIDTH-1:0]               apb_paddr_out;
    logic [SLAVE_DEVICES-1:0]                apb_psel_out;
    logic                                    apb_penable_out;
    logic                                    apb_pwrite_out;
    logic [APB_DATA_WIDTH-1:0]               apb_pwdata_out;
    logic [SW-1:0]                           apb_pstrb_out;
    logic [2:0]                              apb_pprot_out;
    logic [SLAVE_DEVICES*APB_DATA_WIDTH-1:0] apb_prdata_in;
    logic [SLAVE_DEVICES-1:0]                apb_pready_in;
    logic [SLAVE_DEVICES-1:0]                apb_pslverr_in;

    modport master (
        input  req_valid_in, req_addr_in, req_write_in, req_wdata_in, req_strb_in, req_prot_in,
        input  rsp_ready_in, apb_prdata_in, apb_pready_in, apb_pslverr_in,
        output req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out,
        output apb_paddr_out, apb_psel_out, apb_penable_out, apb_pwrite_out,
        output apb_pwdata_out, apb_pstrb_out, apb_pprot_out
    );

    modport slave (
        output req_valid_in, req_addr_in, req_write_in, req_wdata_in, req_strb_in, req_prot_in,
        output rsp_ready_in, apb_prdata_in, apb_pready_in, apb_pslverr_in,
        input  req_ready_out, rsp_valid_out, rsp_rdata_out, rsp_err_out,
        input  apb_paddr_out, apb_psel_out, apb_penable_out, apb_pwrite_out,
        input  apb_pwdata_out, apb_pstrb_out, apb_pprot_out
    );
endinterface

// File: rtl/apb_master_mc.sv
// apb_master_mc: single-request APB master bridge decoding an address onto one of several psel lines
module apb_master_mc #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int SLAVE_DEVICES  = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLE  = 16
) (
    input logic            apb_clk_in,
    input logic            apb_rstn_in,
    apb_master_mc_if.master bus
);
    localparam int DW = APB_DATA_WIDTH;
    localparam int AW = APB_ADDR_WIDTH;
    localparam int SW = DW / 8;
    // index field is one bit wider than the slave count needs so out-of-range selects are detectable
    localparam int IW = $clog2(SLAVE_DEVICES + 1);
    localparam int CW = (TIMEOUT_CYCLE > 1) ? $clog2(TIMEOUT_CYCLE + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   strb_q, strb_d;
    logic [2:0]      prot_q, prot_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      err_q, err_d;

    logic [IW-1:0]            req_idx;
    logic [DW-1:0]            prdata_sel;
    logic                     pready_sel;
    logic                     pslverr_sel;
    logic [SLAVE_DEVICES-1:0] psel_1h;
    logic                     active;
    logic                     rsp_v;

    assign req_idx = bus.req_addr_in[SEL_LSB +: IW];
    assign active  = (state_q == SETUP) || (state_q == ACCESS);
    assign rsp_v   = (state_q == RESP);

    // mux the addressed slave's return signals and build the one-hot select
    always_comb begin
        prdata_sel  = '0;
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        psel_1h     = '0;
        for (int i = 0; i < SLAVE_DEVICES; i++) begin
            if (idx_q == IW'(i)) begin
                prdata_sel  = bus.apb_prdata_in[i*DW +: DW];
                pready_sel  = bus.apb_pready_in[i];
                pslverr_sel = bus.apb_pslverr_in[i];
                psel_1h[i]  = 1'b1;
            end
        end
    end

    // next-state and datapath capture for the transfer sequencer
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        prot_d  = prot_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_in) begin
                    addr_d  = bus.req_addr_in;
                    write_d = bus.req_write_in;
                    wdata_d = bus.req_write_in ? bus.req_wdata_in : '0;
                    strb_d  = bus.req_write_in ? bus.req_strb_in : '0;
                    prot_d  = bus.req_prot_in;
                    idx_d   = req_idx;
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = (req_idx < IW'(SLAVE_DEVICES)) ? 2'b00 : 2'b11;
                    state_d = (req_idx < IW'(SLAVE_DEVICES)) ? SETUP : RESP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_sel) begin
                    rdata_d = (write_q || pslverr_sel) ? '0 : prdata_sel;
                    err_d   = pslverr_sel ? 2'b01 : 2'b00;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLE - 1)) begin
                    rdata_d = '0;
                    err_d   = 2'b10;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: state_d = bus.rsp_ready_in ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // state and captured request/response registers, cleared asynchronously
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            prot_q  <= prot_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready_out   = (state_q == IDLE);
    assign bus.rsp_valid_out   = rsp_v;
    assign bus.rsp_rdata_out   = rsp_v ? rdata_q : '0;
    assign bus.rsp_err_out     = rsp_v ? err_q : 2'b00;
    assign bus.apb_paddr_out   = active ? addr_q : '0;
    assign bus.apb_psel_out    = active ? psel_1h : '0;
    assign bus.apb_penable_out = (state_q == ACCESS);
    assign bus.apb_pwrite_out  = active ? write_q : 1'b0;
    assign bus.apb_pwdata_out  = active ? wdata_q : '0;
    assign bus.apb_pstrb_out   = active ? strb_q : '0;
    assign bus.apb_pprot_out   = active ? prot_q : 3'b000;
endmodule

// File: tb/tb_apb_master_mc.sv
// tb_apb_master_mc: directed stimulus with a response scoreboard and a simple APB slave model
module tb_apb_master_mc;
    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_rsp = 0;
    int   rsp_cyc = 0;
    bit   seen = 0;
    int   t0 = 0;
    int   waits = 0;
    bit   slv_err = 0;
    bit   noise = 0;
    logic [31:0] rd_data = '0;
    exp_t exp_q[$];

    apb_master_mc_if #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .SLAVE_DEVICES(4)) bus();

    apb_master_mc #(
        .APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .SLAVE_DEVICES(4),
        .SEL_LSB(12), .TIMEOUT_CYCLE(16)
    ) dut (
        .apb_clk_in (clk),
        .apb_rstn_in(rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // slave model: the selected slave answers after 'waits' ACCESS cycles (never when waits<0)
    int acc = 0;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            bus.apb_pready_in[i]         = noise && !bus.apb_psel_out[i];
            bus.apb_pslverr_in[i]        = noise && !bus.apb_psel_out[i];
            bus.apb_prdata_in[i*32 +: 32] = noise ? 32'hBAD0BAD0 : 32'h0;
        end
        if (bus.apb_penable_out) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.apb_psel_out[i]) begin
                    bus.apb_pready_in[i]          = (waits >= 0) && (acc == waits);
                    bus.apb_pslverr_in[i]         = slv_err;
                    bus.apb_prdata_in[i*32 +: 32] = rd_data;
                end
            end
            acc++;
        end else begin
            acc = 0;
        end
    end

    // response monitor: pops the scoreboard on every response handshake
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            seen = 0;
        end else if (bus.rsp_valid_out) begin
            if (!seen) begin
                seen = 1;
                rsp_cyc = cyc;
            end
            if (bus.rsp_ready_in) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", 64'(bus.rsp_rdata_out), 64'(e.rdata));
                    check("rsp_err", 64'(bus.rsp_err_out), 64'(e.err));
                end
                seen = 0;
                n_rsp++;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        int n = 0;
        @(negedge clk);
        bus.req_valid_in = 1'b1;
        bus.req_addr_in  = a;
        bus.req_write_in = w;
        bus.req_wdata_in = d;
        bus.req_strb_in  = s;
        bus.req_prot_in  = p;
        while (!bus.req_ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready_out) check("req_accept_timeout", 64'd0, 64'd1);
        t0 = cyc;
        @(negedge clk);
        bus.req_valid_in = 1'b0;
    endtask

    task automatic observe(output int ps, output int pe);
        int n = 0;
        ps = 0;
        pe = 0;
        while (bus.apb_psel_out != 0 && n < 100) begin
            ps++;
            if (bus.apb_penable_out) pe++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_rsp(input int target);
        int n = 0;
        while (n_rsp < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n_rsp < target) check("rsp_wait_timeout", 64'(n_rsp), 64'(target));
    endtask

    int ps, pe;

    initial begin
        rst_n = 1'b0;
        bus.req_valid_in = 1'b0;
        bus.req_addr_in  = '0;
        bus.req_write_in = 1'b0;
        bus.req_wdata_in = '0;
        bus.req_strb_in  = '0;
        bus.req_prot_in  = '0;
        bus.rsp_ready_in = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready_out), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid_out), 64'd0);
        check("rst_psel", 64'(bus.apb_psel_out), 64'd0);
        check("rst_penable", 64'(bus.apb_penable_out), 64'd0);
        check("rst_paddr", 64'(bus.apb_paddr_out), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // write, zero wait states, slave 2
        waits = 0; slv_err = 0; noise = 0; rd_data = 32'h0;
        exp_q.push_back('{rdata: 32'h0, err: 2'b00});
        send(32'h0000_2004, 1'b1, 32'hDEADBEEF, 4'hF, 3'b010);
        check("t1_psel", 64'(bus.apb_psel_out), 64'h4);
        check("t1_penable_setup", 64'(bus.apb_penable_out), 64'd0);
        check("t1_paddr", 64'(bus.apb_paddr_out), 64'h2004);
        check("t1_pwdata", 64'(bus.apb_pwdata_out), 64'hDEADBEEF);
        check("t1_pstrb", 64'(bus.apb_pstrb_out), 64'hF);
        check("t1_pwrite", 64'(bus.apb_pwrite_out), 64'd1);
        check("t1_pprot", 64'(bus.apb_pprot_out), 64'h2);
        observe(ps, pe);
        check("t1_psel_cycles", 64'(ps), 64'd2);
        check("t1_penable_cycles", 64'(pe), 64'd1);
        wait_rsp(1);
        check("t1_latency", 64'(rsp_cyc - t0), 64'd3);
        check("t1_idle_paddr", 64'(bus.apb_paddr_out), 64'd0);

        // read, three wait states, slave 1; wdata/strb must be forced low
        waits = 3; rd_data = 32'h12345678;
        exp_q.push_back('{rdata: 32'h12345678, err: 2'b00});
        send(32'h0000_1010, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b000);
        check("t2_psel", 64'(bus.apb_psel_out), 64'h2);
        check("t2_pstrb", 64'(bus.apb_pstrb_out), 64'h0);
        check("t2_pwdata", 64'(bus.apb_pwdata_out), 64'h0);
        check("t2_pwrite", 64'(bus.apb_pwrite_out), 64'd0);
        observe(ps, pe);
        check("t2_penable_cycles", 64'(pe), 64'd4);
        wait_rsp(2);
        check("t2_latency", 64'(rsp_cyc - t0), 64'd6);

        // read slave 0 with pslverr, other slaves noisy
        waits = 0; slv_err = 1; noise = 1; rd_data = 32'hCAFEF00D;
        exp_q.push_back('{rdata: 32'h0, err: 2'b01});
        send(32'h0000_0000, 1'b0, 32'h0, 4'h0, 3'b000);
        check("t3_psel", 64'(bus.apb_psel_out), 64'h1);
        wait_rsp(3);

        // slave 3 never ready: timeout after 16 ACCESS cycles
        waits = -1; slv_err = 0; noise = 0;
        exp_q.push_back('{rdata: 32'h0, err: 2'b10});
        send(32'h0000_3000, 1'b0, 32'h0, 4'h0, 3'b000);
        check("t4_psel", 64'(bus.apb_psel_out), 64'h8);
        observe(ps, pe);
        check("t4_psel_cycles", 64'(ps), 64'd17);
        check("t4_penable_cycles", 64'(pe), 64'd16);
        wait_rsp(4);

        // decode error with response back-pressure
        bus.rsp_ready_in = 1'b0;
        exp_q.push_back('{rdata: 32'h0, err: 2'b11});
        send(32'h0000_5000, 1'b1, 32'h1111_2222, 4'hF, 3'b000);
        for (int k = 0; k < 5; k++) begin
            check("t5_rsp_valid", 64'(bus.rsp_valid_out), 64'd1);
            check("t5_rsp_err_hold", 64'(bus.rsp_err_out), 64'h3);
            check("t5_req_ready", 64'(bus.req_ready_out), 64'd0);
            check("t5_psel", 64'(bus.apb_psel_out), 64'd0);
            @(negedge clk);
        end
        bus.rsp_ready_in = 1'b1;
        wait_rsp(5);
        check("t5_latency", 64'(rsp_cyc - t0), 64'd1);

        // reset asserted mid-ACCESS, then a normal transfer
        waits = -1;
        send(32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'b000);
        @(negedge clk);
        check("t6_in_access", 64'(bus.apb_penable_out), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_psel", 64'(bus.apb_psel_out), 64'd0);
        check("t6_rst_penable", 64'(bus.apb_penable_out), 64'd0);
        check("t6_rst_rsp_valid", 64'(bus.rsp_valid_out), 64'd0);
        check("t6_rst_req_ready", 64'(bus.req_ready_out), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_no_rsp", 64'(bus.rsp_valid_out), 64'd0);
        waits = 1;
        exp_q.push_back('{rdata: 32'h0, err: 2'b00});
        send(32'h0000_2008, 1'b1, 32'hA5A5_5A5A, 4'h3, 3'b000);
        check("t6_psel", 64'(bus.apb_psel_out), 64'h4);
        observe(ps, pe);
        check("t6_penable_cycles", 64'(pe), 64'd2);
        wait_rsp(6);
        check("t6_rsp_count", 64'(n_rsp), 64'd6);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
